// File: rtl/dual_port_ram_20_pkg.sv
// Shared definitions for the dual_port_ram_20 storage element.
// - rdw_mode_e selects what a read returns when a commit lands on the
//   same word at the read's sample edge.
// - params_ok() is evaluated at elaboration by the top level to reject
//   unusable parameter combinations.
package dpram_pkg;

    typedef enum logic [0:0] {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    localparam int MIN_LATENCY = 32'sd1;

    // Word width must split into whole byte lanes and both pipelines need at least one edge.
    function automatic bit params_ok(
        input int data_width,
        input int byte_width,
        input int rd_latency,
        input int wr_latency
    );
        bit ok;
        ok = 1'b1;
        if (byte_width <= 32'sd0) begin
            ok = 1'b0;
        end else if ((data_width % byte_width) != 32'sd0) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        if ((rd_latency < MIN_LATENCY) || (wr_latency < MIN_LATENCY)) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

endpackage

// File: rtl/dual_port_ram_20_if.sv
// Request/response bundle for both ports of dual_port_ram_20.
// master: drives requests (i_en*, i_we*, i_be*, i_addr*, i_din*) and
//         receives o_dout*, o_valid*, o_collision.
// slave : the RAM side of the same signals.
interface dual_port_ram_20_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  i_ena;
    logic                  i_enb;
    logic                  i_wea;
    logic                  i_web;
    logic [NB-1:0]         i_bea;
    logic [NB-1:0]         i_beb;
    logic [ADDR_WIDTH-1:0] i_addra;
    logic [ADDR_WIDTH-1:0] i_addrb;
    logic [DATA_WIDTH-1:0] i_dina;
    logic [DATA_WIDTH-1:0] i_dinb;
    logic [DATA_WIDTH-1:0] o_douta;
    logic [DATA_WIDTH-1:0] o_doutb;
    logic                  o_valida;
    logic                  o_validb;
    logic                  o_collision;

    modport master (
        output i_ena, i_enb, i_wea, i_web, i_bea, i_beb,
               i_addra, i_addrb, i_dina, i_dinb,
        input  o_douta, o_doutb, o_valida, o_validb, o_collision
    );

    modport slave (
        input  i_ena, i_enb, i_wea, i_web, i_bea, i_beb,
               i_addra, i_addrb, i_dina, i_dinb,
        output o_douta, o_doutb, o_valida, o_validb, o_collision
    );

endinterface

// File: rtl/dual_port_ram_20_delay_line.sv
// dpram_delay_line: DEPTH-stage register pipeline of WIDTH bits.
// DEPTH = 0 degenerates to a wire.
// Ports: clk, rst_n (async active-low, clears every stage to 0),
//        din (stage input), dout (oldest stage / din when DEPTH = 0).
module dpram_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_s;
            assign unused_s = clk ^ rst_n;
            assign dout     = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift register; reset discards everything in flight.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= '0;
                    end
                end else begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dual_port_ram_20.sv
// dual_port_ram_20: single-clock true-dual-port RAM with byte enables,
// separate read/write pipeline latencies, per-read valid strobes,
// deterministic same-word write collision resolution and selectable
// read-during-write behaviour.
// Ports:
//   i_clk   - sole clock
//   i_rst_n - asynchronous active-low reset (pipelines/outputs only)
//   bus     - dual_port_ram_20_if.slave: per-port en/we/be/addr/din in,
//             dout/valid out, plus o_collision
module dual_port_ram_20
    import dpram_pkg::*;
#(
    parameter int        ADDR_WIDTH    = 4,
    parameter int        DATA_WIDTH    = 16,
    parameter int        BYTE_WIDTH    = 8,
    parameter int        READ_LATENCY  = 2,
    parameter int        WRITE_LATENCY = 2,
    parameter rdw_mode_e RDW_MODE      = READ_FIRST,
    parameter bit        PRIO_A        = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    dual_port_ram_20_if.slave  bus
);

    localparam int NB          = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH_WORDS = 2 ** ADDR_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [NB-1:0]         be;
    } wr_req_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } rd_req_t;

    generate
        if (!params_ok(DATA_WIDTH, BYTE_WIDTH, READ_LATENCY, WRITE_LATENCY)) begin : g_param_err
            $error("dual_port_ram_20: DATA_WIDTH must be a multiple of BYTE_WIDTH and latencies must be >= 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];

    wr_req_t               wr_in_a_s;
    wr_req_t               wr_in_b_s;
    wr_req_t               cm_a_s;
    wr_req_t               cm_b_s;
    rd_req_t               rd_in_a_s;
    rd_req_t               rd_in_b_s;
    rd_req_t               rd_out_a_s;
    rd_req_t               rd_out_b_s;
    logic [DATA_WIDTH-1:0] nxt_a_s;
    logic [DATA_WIDTH-1:0] nxt_b_s;
    logic [DATA_WIDTH-1:0] rd_word_a_s;
    logic [DATA_WIDTH-1:0] rd_word_b_s;
    logic                  collision_s;

    logic [DATA_WIDTH-1:0] douta_r;
    logic [DATA_WIDTH-1:0] doutb_r;
    logic                  valida_r;
    logic                  validb_r;
    logic                  collision_r;

    // Word at addr after this edge's commits; a lane written by both ports takes the priority port.
    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] cur,
        input wr_req_t               ca,
        input wr_req_t               cb
    );
        logic [DATA_WIDTH-1:0] w;
        logic                  hit_a;
        logic                  hit_b;
        w = cur;
        for (int b = 0; b < NB; b++) begin
            hit_a = ca.valid && (ca.addr == addr) && ca.be[b];
            hit_b = cb.valid && (cb.addr == addr) && cb.be[b];
            if (hit_a && hit_b) begin
                if (PRIO_A) begin
                    w[b*BYTE_WIDTH +: BYTE_WIDTH] = ca.data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end else begin
                    w[b*BYTE_WIDTH +: BYTE_WIDTH] = cb.data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end else if (hit_a) begin
                w[b*BYTE_WIDTH +: BYTE_WIDTH] = ca.data[b*BYTE_WIDTH +: BYTE_WIDTH];
            end else if (hit_b) begin
                w[b*BYTE_WIDTH +: BYTE_WIDTH] = cb.data[b*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                w[b*BYTE_WIDTH +: BYTE_WIDTH] = cur[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return w;
    endfunction

    // Accepted requests; gated by reset so a latency-1 write cannot reach the array while in reset.
    always_comb begin
        wr_in_a_s.valid = bus.i_ena & bus.i_wea & i_rst_n;
        wr_in_a_s.addr  = bus.i_addra;
        wr_in_a_s.data  = bus.i_dina;
        wr_in_a_s.be    = bus.i_bea;
        wr_in_b_s.valid = bus.i_enb & bus.i_web & i_rst_n;
        wr_in_b_s.addr  = bus.i_addrb;
        wr_in_b_s.data  = bus.i_dinb;
        wr_in_b_s.be    = bus.i_beb;
        rd_in_a_s.valid = bus.i_ena & ~bus.i_wea & i_rst_n;
        rd_in_a_s.data  = rd_word_a_s;
        rd_in_b_s.valid = bus.i_enb & ~bus.i_web & i_rst_n;
        rd_in_b_s.data  = rd_word_b_s;
    end

    dpram_delay_line #(.DEPTH(WRITE_LATENCY - 1), .WIDTH($bits(wr_req_t))) u_wr_pipe_a (
        .clk(i_clk), .rst_n(i_rst_n), .din(wr_in_a_s), .dout(cm_a_s)
    );

    dpram_delay_line #(.DEPTH(WRITE_LATENCY - 1), .WIDTH($bits(wr_req_t))) u_wr_pipe_b (
        .clk(i_clk), .rst_n(i_rst_n), .din(wr_in_b_s), .dout(cm_b_s)
    );

    dpram_delay_line #(.DEPTH(READ_LATENCY - 1), .WIDTH($bits(rd_req_t))) u_rd_pipe_a (
        .clk(i_clk), .rst_n(i_rst_n), .din(rd_in_a_s), .dout(rd_out_a_s)
    );

    dpram_delay_line #(.DEPTH(READ_LATENCY - 1), .WIDTH($bits(rd_req_t))) u_rd_pipe_b (
        .clk(i_clk), .rst_n(i_rst_n), .din(rd_in_b_s), .dout(rd_out_b_s)
    );

    // Merged next words for both commit addresses, plus overlapping-lane detection.
    always_comb begin
        nxt_a_s     = merge_word(cm_a_s.addr, mem_r[cm_a_s.addr], cm_a_s, cm_b_s);
        nxt_b_s     = merge_word(cm_b_s.addr, mem_r[cm_b_s.addr], cm_a_s, cm_b_s);
        collision_s = cm_a_s.valid && cm_b_s.valid && (cm_a_s.addr == cm_b_s.addr)
                      && (|(cm_a_s.be & cm_b_s.be));
    end

    // Read sample: pre-commit word, or the merged word when the same edge commits to it.
    always_comb begin
        if (RDW_MODE == WRITE_FIRST) begin
            rd_word_a_s = merge_word(bus.i_addra, mem_r[bus.i_addra], cm_a_s, cm_b_s);
            rd_word_b_s = merge_word(bus.i_addrb, mem_r[bus.i_addrb], cm_a_s, cm_b_s);
        end else begin
            rd_word_a_s = mem_r[bus.i_addra];
            rd_word_b_s = mem_r[bus.i_addrb];
        end
    end

    // Storage array; contents survive reset. Same-address commits write identical merged words.
    always_ff @(posedge i_clk) begin
        if (cm_a_s.valid) begin
            mem_r[cm_a_s.addr] <= nxt_a_s;
        end
        if (cm_b_s.valid) begin
            mem_r[cm_b_s.addr] <= nxt_b_s;
        end
    end

    // Read output registers; dout holds between reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            douta_r  <= '0;
            doutb_r  <= '0;
            valida_r <= 1'b0;
            validb_r <= 1'b0;
        end else begin
            valida_r <= rd_out_a_s.valid;
            validb_r <= rd_out_b_s.valid;
            douta_r  <= rd_out_a_s.valid ? rd_out_a_s.data : douta_r;
            doutb_r  <= rd_out_b_s.valid ? rd_out_b_s.data : doutb_r;
        end
    end

    // Collision flag, high for the cycle after the overlapping commit edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            collision_r <= 1'b0;
        end else begin
            collision_r <= collision_s;
        end
    end

    assign bus.o_douta     = douta_r;
    assign bus.o_doutb     = doutb_r;
    assign bus.o_valida    = valida_r;
    assign bus.o_validb    = validb_r;
    assign bus.o_collision = collision_r;

endmodule

// File: tb/tb_dual_port_ram_20.sv
// Scoreboard bench for dual_port_ram_20. Six parameter sets share one
// stimulus stream; a per-configuration cycle model predicts every output.
module tb_dual_port_ram_20;
    import dpram_pkg::*;

    localparam int NCFG = 6;
    localparam int RL_C [NCFG] = '{2, 2, 1, 3, 1, 3};
    localparam int WL_C [NCFG] = '{2, 2, 1, 4, 4, 1};
    localparam bit WF_C [NCFG] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam bit PA_C [NCFG] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    logic        clk;
    logic        rst_n;
    logic        ena, enb, wea, web;
    logic [1:0]  bea, beb;
    logic [3:0]  addra, addrb;
    logic [15:0] dina, dinb;

    logic [15:0] douta [NCFG];
    logic [15:0] doutb [NCFG];
    logic        valida [NCFG];
    logic        validb [NCFG];
    logic        coll [NCFG];

    generate
        for (genvar g = 0; g < NCFG; g++) begin : g_cfg
            dual_port_ram_20_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8)) bus ();
            assign bus.i_ena   = ena;
            assign bus.i_enb   = enb;
            assign bus.i_wea   = wea;
            assign bus.i_web   = web;
            assign bus.i_bea   = bea;
            assign bus.i_beb   = beb;
            assign bus.i_addra = addra;
            assign bus.i_addrb = addrb;
            assign bus.i_dina  = dina;
            assign bus.i_dinb  = dinb;
            assign douta[g]    = bus.o_douta;
            assign doutb[g]    = bus.o_doutb;
            assign valida[g]   = bus.o_valida;
            assign validb[g]   = bus.o_validb;
            assign coll[g]     = bus.o_collision;

            dual_port_ram_20 #(
                .ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8),
                .READ_LATENCY(RL_C[g]), .WRITE_LATENCY(WL_C[g]),
                .RDW_MODE(WF_C[g] ? WRITE_FIRST : READ_FIRST),
                .PRIO_A(PA_C[g])
            ) u_dut (
                .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          acc;
        bit          port;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_ev_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_ev_t;

    wr_ev_t      pend [$];
    rd_ev_t      qa [NCFG][$];
    rd_ev_t      qb [NCFG][$];
    int          qc [NCFG][$];
    logic [15:0] mm [NCFG][16];
    logic [15:0] last_a [NCFG];
    logic [15:0] last_b [NCFG];
    int          cyc;
    int          n_checks;
    int          n_fail;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference merge: low-priority port lanes first, then high-priority lanes on top.
    function automatic logic [15:0] mdl_merge(input int c, input logic [3:0] addr, input logic [15:0] cur,
                                               input bit av, input wr_ev_t aw, input bit bv, input wr_ev_t bw);
        logic [15:0] w, ma, mb;
        w  = cur;
        ma = (av && aw.addr == addr) ? {{8{aw.be[1]}}, {8{aw.be[0]}}} : 16'h0000;
        mb = (bv && bw.addr == addr) ? {{8{bw.be[1]}}, {8{bw.be[0]}}} : 16'h0000;
        if (PA_C[c]) begin
            w = (w & ~mb) | (bw.data & mb);
            w = (w & ~ma) | (aw.data & ma);
        end else begin
            w = (w & ~ma) | (aw.data & ma);
            w = (w & ~mb) | (bw.data & mb);
        end
        return w;
    endfunction

    task automatic model_edge();
        bit          av, bv;
        wr_ev_t      aw, bw, ev;
        logic [15:0] na, nb, rw;
        if (!rst_n) begin
            pend.delete();
            for (int c = 0; c < NCFG; c++) begin
                qa[c].delete();
                qb[c].delete();
                qc[c].delete();
                last_a[c] = 16'h0000;
                last_b[c] = 16'h0000;
            end
            return;
        end
        if (ena && wea) begin
            ev.acc = cyc; ev.port = 1'b0; ev.addr = addra; ev.data = dina; ev.be = bea;
            pend.push_back(ev);
        end
        if (enb && web) begin
            ev.acc = cyc; ev.port = 1'b1; ev.addr = addrb; ev.data = dinb; ev.be = beb;
            pend.push_back(ev);
        end
        for (int c = 0; c < NCFG; c++) begin
            av = 1'b0; bv = 1'b0;
            aw = '{0, 1'b0, 4'h0, 16'h0000, 2'b00};
            bw = aw;
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i].acc + WL_C[c] - 1 == cyc) begin
                    if (pend[i].port == 1'b0) begin av = 1'b1; aw = pend[i]; end
                    else begin bv = 1'b1; bw = pend[i]; end
                end
            end
            if (ena && !wea) begin
                rw = WF_C[c] ? mdl_merge(c, addra, mm[c][addra], av, aw, bv, bw) : mm[c][addra];
                qa[c].push_back('{cyc + RL_C[c] - 1, rw});
            end
            if (enb && !web) begin
                rw = WF_C[c] ? mdl_merge(c, addrb, mm[c][addrb], av, aw, bv, bw) : mm[c][addrb];
                qb[c].push_back('{cyc + RL_C[c] - 1, rw});
            end
            na = mdl_merge(c, aw.addr, mm[c][aw.addr], av, aw, bv, bw);
            nb = mdl_merge(c, bw.addr, mm[c][bw.addr], av, aw, bv, bw);
            if (av) mm[c][aw.addr] = na;
            if (bv) mm[c][bw.addr] = nb;
            if (av && bv && aw.addr == bw.addr && (|(aw.be & bw.be))) qc[c].push_back(cyc);
        end
        while (pend.size() > 0 && pend[0].acc < cyc - 8) void'(pend.pop_front());
    endtask

    task automatic check_outputs();
        bit ea, eb, ec;
        for (int c = 0; c < NCFG; c++) begin
            ea = (qa[c].size() > 0) && (qa[c][0].due == cyc);
            if (ea) begin last_a[c] = qa[c][0].data; void'(qa[c].pop_front()); end
            eb = (qb[c].size() > 0) && (qb[c][0].due == cyc);
            if (eb) begin last_b[c] = qb[c][0].data; void'(qb[c].pop_front()); end
            ec = (qc[c].size() > 0) && (qc[c][0] == cyc);
            if (ec) void'(qc[c].pop_front());
            check_val($sformatf("c%0d_valida", c), 32'(valida[c]), 32'(ea));
            check_val($sformatf("c%0d_douta", c), 32'(douta[c]), 32'(last_a[c]));
            check_val($sformatf("c%0d_validb", c), 32'(validb[c]), 32'(eb));
            check_val($sformatf("c%0d_doutb", c), 32'(doutb[c]), 32'(last_b[c]));
            check_val($sformatf("c%0d_collision", c), 32'(coll[c]), 32'(ec));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_a(input logic en, input logic we, input logic [1:0] be, input logic [3:0] ad, input logic [15:0] d);
        ena = en; wea = we; bea = be; addra = ad; dina = d;
    endtask

    task automatic set_b(input logic en, input logic we, input logic [1:0] be, input logic [3:0] ad, input logic [15:0] d);
        enb = en; web = we; beb = be; addrb = ad; dinb = d;
    endtask

    task automatic idle(input int n);
        set_a(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
        set_b(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
        repeat (n) tick();
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0;
        for (int c = 0; c < NCFG; c++) begin
            last_a[c] = 16'h0000;
            last_b[c] = 16'h0000;
        end
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;

        // Fill every word so later reads are defined; addr 2 holds 0x0001.
        for (int i = 0; i < 16; i++) begin
            set_a(1'b1, 1'b1, 2'b11, 4'(i), (i == 2) ? 16'h0001 : (16'hA000 | 16'(i)));
            tick();
        end
        idle(6);

        // Basic write then read two cycles later on the other port.
        set_a(1'b1, 1'b1, 2'b11, 4'd3, 16'hBEEF); tick();
        idle(1);
        set_b(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000); tick();
        idle(6);

        // Byte-enable update.
        set_a(1'b1, 1'b1, 2'b11, 4'd5, 16'h1234); tick();
        set_a(1'b1, 1'b1, 2'b10, 4'd5, 16'hAB00); tick();
        idle(5);
        set_a(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000); tick();
        idle(6);

        // Full-overlap collision, then disjoint lanes.
        set_a(1'b1, 1'b1, 2'b11, 4'd7, 16'h1111);
        set_b(1'b1, 1'b1, 2'b11, 4'd7, 16'h2222); tick();
        idle(5);
        set_a(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000); tick();
        idle(5);
        set_a(1'b1, 1'b1, 2'b01, 4'd7, 16'h1111);
        set_b(1'b1, 1'b1, 2'b10, 4'd7, 16'h2222); tick();
        idle(5);
        set_a(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000);
        set_b(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000); tick();
        idle(6);

        // Read-during-write: B reads on every edge around A's commit.
        set_a(1'b1, 1'b1, 2'b11, 4'd9, 16'h0F0F); tick();
        idle(6);
        set_a(1'b1, 1'b1, 2'b11, 4'd9, 16'h5555);
        set_b(1'b1, 1'b0, 2'b00, 4'd9, 16'h0000); tick();
        set_a(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
        repeat (4) tick();
        idle(6);

        // Back-to-back reads across the whole array on both ports.
        for (int i = 0; i < 16; i++) begin
            set_a(1'b1, 1'b0, 2'b00, 4'(i), 16'h0000);
            set_b(1'b1, 1'b0, 2'b00, 4'(15 - i), 16'h0000);
            tick();
        end
        idle(6);

        // Reset with a write and a read in flight.
        set_a(1'b1, 1'b1, 2'b11, 4'd2, 16'hDEAD);
        set_b(1'b1, 1'b0, 2'b00, 4'd4, 16'h0000); tick();
        idle(1);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        set_a(1'b1, 1'b0, 2'b00, 4'd2, 16'h0000);
        set_b(1'b1, 1'b0, 2'b00, 4'd2, 16'h0000); tick();
        idle(6);

        // Random mixed traffic on both ports.
        repeat (250) begin
            set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 16'($urandom));
            set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 16'($urandom));
            tick();
        end
        idle(8);

        for (int c = 0; c < NCFG; c++) begin
            check_val($sformatf("c%0d_drain_a", c), 32'(qa[c].size()), 32'd0);
            check_val($sformatf("c%0d_drain_b", c), 32'(qb[c].size()), 32'd0);
            check_val($sformatf("c%0d_drain_c", c), 32'(qc[c].size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
